dmem_responder: RTL and testbench

//  Word-addressed data-memory target with valid/ready request and response channels,

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-addressed data-memory target serving one outstanding
//               access at a time over valid/ready request and response
//               channels. Supports byte-lane write enables and a fixed,
//               configurable access latency. Every access returns the word
//               as it was before any write.
//
// Ports       : clk_i          rising-edge clock
//               rst_i          asynchronous active-high reset
//               req_valid_i    request present
//               req_ready_o    request accepted on the next edge (IDLE only)
//               req_addr_i     byte address
//               req_wdata_i    store data
//               req_we_i       byte-lane write enables, 0 = load
//               resp_valid_o   response present
//               resp_ready_i   initiator takes the response
//               resp_rdata_o   pre-write word at the addressed location
//               resp_err_o     access was misaligned or out of range
//
// Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_LOG2 = 13,
    parameter int LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_we_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // The accepting edge itself accounts for one latency edge and the edge
    // leaving WAIT for another, so WAIT starts LATENCY-2 ahead of zero.
    localparam int         C_WAIT_CYCLES = (LATENCY > 1) ? (LATENCY - 2) : 0;
    localparam logic [3:0] C_CNT_LOAD    = C_WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    // Storage is deliberately outside the reset domain: contents survive rst_i.
    logic [31:0] mem_q [DEPTH];

    logic                  w_accept;
    logic                  w_err;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_old_word;
    logic [31:0]           w_wmask;
    logic [31:0]           w_new_word;

    assign w_accept   = (state_q == ST_IDLE) && req_valid_i;
    assign w_idx      = req_addr_i[DEPTH_LOG2+1:2];
    assign w_err      = (req_addr_i[1:0] != 2'b00) ||
                        (req_addr_i[31:DEPTH_LOG2+2] != '0);
    assign w_old_word = mem_q[w_idx];

    // Expand the four lane enables into a bit mask over the word.
    for (genvar i = 0; i < 4; i++) begin : g_lane_mask
        assign w_wmask[8*i +: 8] = {8{req_we_i[i]}};
    end

    assign w_new_word = (w_old_word & ~w_wmask) | (req_wdata_i & w_wmask);

    // Write commits on the accepting edge; erroneous accesses write nothing.
    always_ff @(posedge clk_i) begin
        if (w_accept && !w_err && (req_we_i != 4'b0000)) begin
            mem_q[w_idx] <= w_new_word;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end

                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_ready_q  <= 1'b0;
                        resp_err_q   <= w_err;
                        // Capture the pre-write word; the store lands on the
                        // same edge, so loads and stores both see old data.
                        resp_rdata_q <= w_err ? 32'd0 : w_old_word;
                        if (LATENCY == 1) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= C_CNT_LOAD;
                        end
                    end
                end

                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                ST_RESP: begin
                    // Handshake edge returns to IDLE; a request presented on
                    // this edge is not taken because the state is still RESP.
                    if (resp_ready_i) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q      <= ST_INIT;
                    req_ready_q  <= 1'b0;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Three instances with
//               LATENCY 2, 1 and 5 share clock and reset. A behavioural
//               memory model (associative array of words) predicts read data,
//               error flags and response timing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N-1:0] resp_valid;
    logic [N-1:0] resp_ready;
    logic [N-1:0] resp_err;
    logic [31:0]  req_addr   [N];
    logic [31:0]  req_wdata  [N];
    logic [3:0]   req_we     [N];
    logic [31:0]  resp_rdata [N];

    int n_checks = 0;
    int n_errors = 0;

    // Reference memory: key = instance * 8192 + word index.
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        dmem_responder #(
            .DEPTH_LOG2 (13),
            .LATENCY    ((k == 0) ? 2 : ((k == 1) ? 1 : 5))
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .req_valid_i  (req_valid[k]),
            .req_ready_o  (req_ready[k]),
            .req_addr_i   (req_addr[k]),
            .req_wdata_i  (req_wdata[k]),
            .req_we_i     (req_we[k]),
            .resp_valid_o (resp_valid[k]),
            .resp_ready_i (resp_ready[k]),
            .resp_rdata_o (resp_rdata[k]),
            .resp_err_o   (resp_err[k])
        );
    end

    function automatic int lat(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access on instance k, checked against the model.
    task automatic access(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] we, input int stall, input bit hold,
                          output logic [31:0] rd, output logic er);
        int          e;
        bit          exp_err;
        int          key;
        bit          known;
        logic [31:0] mask;
        e = 0;
        while (!req_ready[k] && e < 20) begin
            tick();
            e++;
        end
        check_eq("req_ready_wait", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_we[k]    = we;
        tick();                         // accepting edge
        req_valid[k] = 1'b0;            // remaining request fields become don't-care
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_we[k]    = 4'($urandom);
        check_eq("req_ready_after_accept", 32'(req_ready[k]), 32'd0);
        e = 1;
        while (!resp_valid[k] && e < lat(k) + 4) begin
            tick();
            e++;
        end
        check_eq("latency_edges", 32'(e), 32'(lat(k)));

        exp_err = (addr[1:0] != 2'b00) || (addr >= 32'h0000_8000);
        key     = k * 8192 + int'(addr[14:2]);
        known   = mdl.exists(key);
        check_eq("resp_err", 32'(resp_err[k]), 32'(exp_err));
        if (exp_err) check_eq("rdata_on_err", resp_rdata[k], 32'd0);
        else if (known) check_eq("rdata", resp_rdata[k], mdl[key]);
        rd = resp_rdata[k];
        er = resp_err[k];

        if (!exp_err && we != 4'b0000) begin
            mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
            if (known) mdl[key] = (mdl[key] & ~mask) | (wdata & mask);
            else if (we == 4'hF) mdl[key] = wdata;
        end

        // Optional competing request held through the stall and handshake.
        if (hold) begin
            req_valid[k] = 1'b1;
            req_addr[k]  = 32'h4;
            req_we[k]    = 4'hF;
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            check_eq("stall_valid", 32'(resp_valid[k]), 32'd1);
            check_eq("stall_rdata", resp_rdata[k], rd);
            check_eq("stall_err", 32'(resp_err[k]), 32'(er));
            check_eq("stall_req_ready", 32'(req_ready[k]), 32'd0);
        end
        resp_ready[k] = 1'b1;
        tick();                         // handshake edge
        resp_ready[k] = 1'b0;
        req_valid[k]  = 1'b0;
        check_eq("valid_cleared", 32'(resp_valid[k]), 32'd0);
        check_eq("req_ready_back", 32'(req_ready[k]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          e;
        int          r;
        logic [31:0] a;

        // T1: reset with requests presented
        for (int k = 0; k < N; k++) begin
            req_valid[k]  = 1'b1;
            req_addr[k]   = 32'h0;
            req_wdata[k]  = 32'hFFFF_FFFF;
            req_we[k]     = 4'hF;
            resp_ready[k] = 1'b0;
        end
        rst = 1'b1;
        tick(); tick(); tick();
        for (int k = 0; k < N; k++) begin
            check_eq("rst_req_ready", 32'(req_ready[k]), 32'd0);
            check_eq("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
            check_eq("rst_rdata", resp_rdata[k], 32'd0);
            check_eq("rst_err", 32'(resp_err[k]), 32'd0);
        end
        rst = 1'b0;
        #1;
        check_eq("init_req_ready", 32'(req_ready[0]), 32'd0);
        tick();
        for (int k = 0; k < N; k++) begin
            check_eq("post_rst_req_ready", 32'(req_ready[k]), 32'd1);
            req_valid[k] = 1'b0;
        end

        // T2: store then load, LATENCY=2
        access(0, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, er);
        access(0, 32'h8, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check_eq("t2_load", rd, 32'hDEAD_BEEF);
        check_eq("t2_err", 32'(er), 32'd0);

        // T3: single-lane store returns pre-write word
        access(0, 32'h8, 32'h0000_AA00, 4'b0010, 0, 1'b0, rd, er);
        check_eq("t3_store_resp", rd, 32'hDEAD_BEEF);
        access(0, 32'h8, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check_eq("t3_load", rd, 32'hDEAD_AAEF);

        // T4: backpressured response with a competing request held
        access(0, 32'h8, 32'h0, 4'h0, 5, 1'b1, rd, er);
        check_eq("t4_rdata", rd, 32'hDEAD_AAEF);

        // T5: erroneous stores leave memory untouched
        access(0, 32'h0, 32'h1111_1111, 4'hF, 0, 1'b0, rd, er);
        access(0, 32'h4, 32'h2222_2222, 4'hF, 0, 1'b0, rd, er);
        access(0, 32'h6, 32'hBAD0_BAD0, 4'hF, 0, 1'b0, rd, er);
        check_eq("t5_mis_err", 32'(er), 32'd1);
        check_eq("t5_mis_rdata", rd, 32'd0);
        access(0, 32'h8000, 32'hBAD1_BAD1, 4'hF, 0, 1'b0, rd, er);
        check_eq("t5_oor_err", 32'(er), 32'd1);
        check_eq("t5_oor_rdata", rd, 32'd0);
        access(0, 32'h4, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check_eq("t5_word4", rd, 32'h2222_2222);
        access(0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check_eq("t5_word0", rd, 32'h1111_1111);

        // T6: reset during WAIT on the LATENCY=5 instance
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h10;
        req_wdata[2] = 32'h1234_5678;
        req_we[2]    = 4'hF;
        tick();
        req_valid[2] = 1'b0;
        mdl[2 * 8192 + 4] = 32'h1234_5678;
        tick();
        rst = 1'b1;
        #1;
        check_eq("t6_valid_async", 32'(resp_valid[2]), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("t6_valid_never", 32'(resp_valid[2]), 32'd0);
        end
        access(2, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
        check_eq("t6_persist", rd, 32'h1234_5678);

        // Reset while a response is pending (LATENCY=1 instance)
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h20;
        req_we[1]    = 4'h0;
        tick();
        req_valid[1] = 1'b0;
        check_eq("rr_valid_before", 32'(resp_valid[1]), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rr_valid_async", 32'(resp_valid[1]), 32'd0);
        check_eq("rr_rdata_async", resp_rdata[1], 32'd0);
        tick();
        rst = 1'b0;

        // T2 repeated for LATENCY=1 and LATENCY=5
        for (int k = 1; k < N; k++) begin
            access(k, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, er);
            access(k, 32'h8, 32'h0, 4'h0, 1, 1'b0, rd, er);
            check_eq("t2r_load", rd, 32'hDEAD_BEEF);
        end

        // Randomized traffic against the model
        for (int k = 0; k < N; k++) begin
            for (int w = 0; w < 8; w++)
                access(k, 32'(w * 4), $urandom, 4'hF, 0, 1'b0, rd, er);
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 9);
                if (r < 8)       a = 32'(r * 4);
                else if (r == 8) a = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
                else             a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_8000;
                access(k, a, $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, er);
            end
        end

        e = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
